program_loader: RTL and testbench
=================================

# program_loader

Boot-time instruction loader that sits directly upstream of the pipelined MIPS datapath's instruction memory. It accepts a big-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words. It writes each word to consecutive word-aligned instruction-memory addresses starting at 0. The datapath is held in reset until the programmed word count has been written.

## Interface

Parameters:
- ADDR_WIDTH, 8: word-address width. Capacity is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_start  input  1  load request, sampled only in IDLE, DONE and ERROR.
- i_word_count  input  ADDR_WIDTH+1  number of words to load; latched when i_start is accepted.
- i_byte_valid  input  1  i_byte_data is valid this cycle.
- i_byte_data  input  8  stream byte.
- o_byte_ready  output  1  loader accepts a byte this cycle.
- o_imem_we  output  1  instruction-memory write enable.
- o_imem_addr  output  32  byte address (word index << 2, bits [1:0] = 0).
- o_imem_wdata  output  32  assembled instruction word.
- o_cpu_reset_n  output  1  active-low reset to the datapath; 1 only in DONE.
- o_busy  output  1  high in RECV and WRITE.
- o_done  output  1  high in DONE.
- o_error  output  1  high in ERROR.

## Operation

- FSM states: IDLE, RECV, WRITE, DONE, ERROR. All outputs are registered or decoded from the state register only.
- Reset values: state IDLE; byte index, word index and assembly register 0. o_byte_ready, o_imem_we, o_busy, o_done, o_error = 0. o_imem_addr = 0, o_imem_wdata = 0, o_cpu_reset_n = 0.
- IDLE / DONE / ERROR on i_start=1:
  - Latch i_word_count.
  - If the count is 0 or greater than 2^ADDR_WIDTH, go to ERROR.
  - Otherwise clear the byte and word indices and go to RECV.
  - Leaving DONE drops o_cpu_reset_n to 0 on the same edge.
- RECV:
  - o_byte_ready=1. A byte is accepted only on i_byte_valid & o_byte_ready.
  - Assembly is big-endian: the first byte goes to [31:24] and the fourth to [7:0] (shift-left-by-8 insert).
  - Byte index wraps 3→0. Accepting the 4th byte moves to WRITE.
- WRITE (exactly one cycle):
  - o_imem_we=1, o_imem_addr={word_index,2'b00} zero-extended, o_imem_wdata=assembled word.
  - o_byte_ready=0.
  - Next state is DONE if word_index+1 equals the latched count; otherwise increment word_index and return to RECV.
- DONE: o_done=1, o_cpu_reset_n=1. The state holds indefinitely.
- ERROR: o_error=1, o_cpu_reset_n=0. The state holds until a valid i_start.
- i_start is ignored in RECV and WRITE. i_byte_valid is ignored outside RECV.
- Word index arithmetic is ADDR_WIDTH+1 bits wide, so a full-capacity load (count = 2^ADDR_WIDTH) terminates without overflow. The last address written is (2^ADDR_WIDTH − 1)·4.

## Timing

- i_start is accepted at edge E. RECV begins after E.
- With continuous valid, bytes are accepted at edges E+1…E+4 and WRITE occupies the cycle after E+4. The next word's bytes follow at E+6…E+9.
- N words take 5N cycles: o_done rises after edge E+5N.
- o_imem_we is a single-cycle pulse per word. There are never two consecutive write cycles.
- Bubbles on i_byte_valid stretch RECV only. The data and address sequence is unchanged.
- Asynchronous reset during any state forces the reset values immediately; a partially assembled word is discarded. After release, the next load restarts at address 0.
- Error detection adds no delay: ERROR is entered on the accepting edge.

## Test plan

- Reset check: hold reset=0, toggle the clock and drive random inputs. Required: all outputs stay at reset values (o_cpu_reset_n=0, o_byte_ready=0, o_imem_we=0).
- Two-word load: i_word_count=2, then stream 20 08 00 05 00 00 00 00 with valid held high. Required:
  - write addr 0x0 data 0x20080005, then addr 0x4 data 0x00000000;
  - o_done and o_cpu_reset_n rise 10 cycles after start.
- Bubbled stream: same bytes with valid low on alternate cycles. Required: the same two writes, exactly two we pulses, and o_byte_ready high throughout RECV.
- Bad count: i_start with count 0. Required: o_error=1 after one edge and no writes. Then i_start with count 1 and bytes 00 00 00 0C. Required: o_error clears, one write of 0x0000000C to addr 0x0, then DONE.
- Reset mid-load: assert reset after 6 bytes of a 3-word load. Required: immediate reset values. After reload, the first write is at addr 0x0.
- Restart and ignore:
  - Pulse i_start during RECV. Required: no effect.
  - Pulse i_start in DONE. Required: o_cpu_reset_n=0 on the next edge and a new load from addr 0.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot-time program loader.
// Stream handshake: a byte moves on a rising edge where i_byte_valid && o_byte_ready; valid may drop at any time.
interface program_loader_if;
  logic        i_byte_valid;
  logic [7:0]  i_byte_data;
  logic        o_byte_ready;
  logic        o_imem_we;
  logic [31:0] o_imem_addr;
  logic [31:0] o_imem_wdata;

  modport master (
    output i_byte_valid, i_byte_data,
    input  o_byte_ready, o_imem_we, o_imem_addr, o_imem_wdata
  );

  modport slave (
    input  i_byte_valid, i_byte_data,
    output o_byte_ready, o_imem_we, o_imem_addr, o_imem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Assembles a big-endian byte stream into 32-bit words, writes them to instruction memory from
// address 0 upward, and holds the datapath in reset until the requested word count is written.
module program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_word_count,
  program_loader_if.slave       bus,
  output logic                  o_cpu_reset_n,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [31:0]           asm_q, asm_d;
  logic [ADDR_WIDTH:0]   word_inc;
  logic                  count_bad;

  // One extra bit on the word counter lets a full-capacity load (2^ADDR_WIDTH) be compared exactly.
  assign word_inc  = word_idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign count_bad = (i_word_count == '0) ||
                     (i_word_count[ADDR_WIDTH] && (|i_word_count[ADDR_WIDTH-1:0]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      count_q    <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
      asm_q      <= asm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    asm_d      = asm_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          count_d = i_word_count;
          if (count_bad) begin
            state_d = S_ERROR;
          end else begin
            byte_idx_d = '0;
            word_idx_d = '0;
            asm_d      = '0;
            state_d    = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (bus.i_byte_valid) begin
          asm_d      = {asm_q[23:0], bus.i_byte_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (word_inc == count_q) begin
          state_d = S_DONE;
        end else begin
          word_idx_d = word_inc;
          state_d    = S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is a decode of registered state, so none glitch on stream inputs.
  assign bus.o_byte_ready = (state_q == S_RECV);
  assign bus.o_imem_we    = (state_q == S_WRITE);
  assign bus.o_imem_addr  = (state_q == S_WRITE) ?
                            {{(32-ADDR_WIDTH-3){1'b0}}, word_idx_q, 2'b00} : 32'h0;
  assign bus.o_imem_wdata = (state_q == S_WRITE) ? asm_q : 32'h0;
  assign o_cpu_reset_n    = (state_q == S_DONE);
  assign o_busy           = (state_q == S_RECV) || (state_q == S_WRITE);
  assign o_done           = (state_q == S_DONE);
  assign o_error          = (state_q == S_ERROR);
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: scenario tasks plus a write scoreboard fed by the stimulus.
module tb_program_loader;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [AW:0]   word_count;
  logic          cpu_reset_n, busy, done, error;
  logic [2:0]    dbg_state;

  program_loader_if bus ();

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .i_start      (start),
    .i_word_count (word_count),
    .bus          (bus),
    .o_cpu_reset_n(cpu_reset_n),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_dbg_state  (dbg_state)
  );

  logic [63:0] exp_q[$];
  int chk_cnt   = 0;
  int pass_cnt  = 0;
  int we_cnt    = 0;
  int cyc       = 0;
  int start_cyc = 0;
  int sent      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every write pulse is popped against the queue filled by send_word.
  task automatic monitor_loop();
    logic [63:0] got;
    logic [63:0] exp;
    logic        prev_we;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_imem_we === 1'b1) begin
        we_cnt++;
        got = {bus.o_imem_addr, bus.o_imem_wdata};
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL write_unexpected: got addr=%h data=%h, required no write", got[63:32], got[31:0]);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp)
            $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                     got[63:32], got[31:0], exp[63:32], exp[31:0]);
          else pass_cnt++;
        end
        chk_cnt++;
        if (prev_we !== 1'b0) $display("FAIL write_consecutive: got we in two cycles, required single pulse");
        else pass_cnt++;
      end
      prev_we = bus.o_imem_we;
    end
  endtask

  task automatic do_start(input logic [AW:0] c);
    start      = 1'b1;
    word_count = c;
    @(posedge clk);
    #1;
    start_cyc  = cyc;
    start      = 1'b0;
    sent       = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bubble);
    bit   acc;
    logic exp_r;
    acc = 1'b0;
    if (bubble) begin
      bus.i_byte_valid = 1'b0;
      exp_r = (sent == 0) || (sent % 4 != 0);
      @(negedge clk);
      chk_cnt++;
      if (bus.o_byte_ready !== exp_r)
        $display("FAIL ready_bubble: got ready=%b, required %b (byte %0d)", bus.o_byte_ready, exp_r, sent);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    bus.i_byte_valid = 1'b1;
    bus.i_byte_data  = b;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = bus.o_byte_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      chk_cnt++;
      $display("FAIL byte_timeout: got no ready within 20 cycles, required acceptance of byte %0d", sent);
    end
    bus.i_byte_valid = 1'b0;
    sent++;
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] data, input bit bubble);
    exp_q.push_back({addr, data});
    send_byte(data[31:24], bubble);
    send_byte(data[23:16], bubble);
    send_byte(data[15:8],  bubble);
    send_byte(data[7:0],   bubble);
  endtask

  task automatic wait_done(input int bound, output int lat);
    lat = -1;
    for (int t = 0; t < bound && lat < 0; t++) begin
      @(negedge clk);
      if (done === 1'b1) lat = cyc - start_cyc;
    end
    if (lat < 0) begin
      chk_cnt++;
      $display("FAIL done_timeout: got no o_done within %0d cycles, required done", bound);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      start            = 1'($urandom_range(0, 1));
      word_count       = 9'($urandom_range(0, 511));
      bus.i_byte_valid = 1'($urandom_range(0, 1));
      bus.i_byte_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      chk_cnt++;
      if ({bus.o_byte_ready, bus.o_imem_we, cpu_reset_n, busy, done, error} !== 6'b0 ||
          bus.o_imem_addr !== 32'h0 || bus.o_imem_wdata !== 32'h0 || dbg_state !== 3'd0)
        $display("FAIL reset_outputs: got rdy=%b we=%b crn=%b busy=%b done=%b err=%b addr=%h wd=%h st=%0d, required all 0",
                 bus.o_byte_ready, bus.o_imem_we, cpu_reset_n, busy, done, error,
                 bus.o_imem_addr, bus.o_imem_wdata, dbg_state);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    start            = 1'b0;
    word_count       = '0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte_data  = '0;
    rst_n            = 1'b1;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (busy !== 1'b0 || cpu_reset_n !== 1'b0 || error !== 1'b0)
      $display("FAIL idle_after_reset: got busy=%b crn=%b err=%b, required 0 0 0", busy, cpu_reset_n, error);
    else pass_cnt++;
  endtask

  task automatic test_two_word();
    int lat;
    int w0;
    w0 = we_cnt;
    do_start(9'd2);
    send_word(32'h0, 32'h20080005, 1'b0);
    send_word(32'h4, 32'h00000000, 1'b0);
    wait_done(60, lat);
    chk_cnt++;
    if (lat !== 10) $display("FAIL two_word_latency: got %0d cycles, required 10", lat);
    else pass_cnt++;
    chk_cnt++;
    if (cpu_reset_n !== 1'b1 || done !== 1'b1 || busy !== 1'b0)
      $display("FAIL two_word_done: got crn=%b done=%b busy=%b, required 1 1 0", cpu_reset_n, done, busy);
    else pass_cnt++;
    chk_cnt++;
    if (we_cnt - w0 !== 2) $display("FAIL two_word_pulses: got %0d writes, required 2", we_cnt - w0);
    else pass_cnt++;
  endtask

  task automatic test_bubbled();
    int lat;
    int w0;
    w0 = we_cnt;
    do_start(9'd2);
    send_word(32'h0, 32'h20080005, 1'b1);
    send_word(32'h4, 32'h00000000, 1'b1);
    wait_done(80, lat);
    chk_cnt++;
    if (we_cnt - w0 !== 2 || exp_q.size() != 0)
      $display("FAIL bubbled_writes: got %0d writes, %0d pending, required 2 and 0", we_cnt - w0, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_bad_count();
    int lat;
    int w0;
    w0 = we_cnt;
    do_start(9'd0);
    chk_cnt++;
    if (error !== 1'b1 || cpu_reset_n !== 1'b0 || busy !== 1'b0)
      $display("FAIL bad_count_zero: got err=%b crn=%b busy=%b, required 1 0 0", error, cpu_reset_n, busy);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (we_cnt !== w0 || error !== 1'b1)
      $display("FAIL bad_count_hold: got writes=%0d err=%b, required 0 1", we_cnt - w0, error);
    else pass_cnt++;
    do_start(9'd257);
    chk_cnt++;
    if (error !== 1'b1 || busy !== 1'b0)
      $display("FAIL bad_count_over: got err=%b busy=%b, required 1 0", error, busy);
    else pass_cnt++;
    do_start(9'd1);
    chk_cnt++;
    if (error !== 1'b0 || busy !== 1'b1)
      $display("FAIL bad_count_recover: got err=%b busy=%b, required 0 1", error, busy);
    else pass_cnt++;
    send_word(32'h0, 32'h0000000C, 1'b0);
    wait_done(40, lat);
    chk_cnt++;
    if (lat !== 5 || we_cnt - w0 !== 1)
      $display("FAIL bad_count_load: got lat=%0d writes=%0d, required 5 1", lat, we_cnt - w0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat;
    do_start(9'd3);
    send_word(32'h0, 32'h11223344, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.o_byte_ready, bus.o_imem_we, cpu_reset_n, busy, done, error} !== 6'b0 || dbg_state !== 3'd0)
      $display("FAIL reset_mid: got rdy=%b we=%b crn=%b busy=%b st=%0d, required all 0",
               bus.o_byte_ready, bus.o_imem_we, cpu_reset_n, busy, dbg_state);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_start(9'd1);
    send_word(32'h0, 32'hCAFEF00D, 1'b0);
    wait_done(40, lat);
    chk_cnt++;
    if (lat !== 5) $display("FAIL reset_mid_reload: got lat=%0d, required 5", lat);
    else pass_cnt++;
  endtask

  task automatic test_restart_ignore();
    int lat;
    int w0;
    logic [31:0] d;
    w0 = we_cnt;
    d  = 32'hDEADBEEF;
    do_start(9'd2);
    chk_cnt++;
    if (cpu_reset_n !== 1'b0 || busy !== 1'b1)
      $display("FAIL restart_from_done: got crn=%b busy=%b, required 0 1", cpu_reset_n, busy);
    else pass_cnt++;
    exp_q.push_back({32'h0, d});
    send_byte(d[31:24], 1'b0);
    send_byte(d[23:16], 1'b0);
    start      = 1'b1;
    word_count = 9'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk_cnt++;
    if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0)
      $display("FAIL start_in_recv: got busy=%b done=%b err=%b, required 1 0 0", busy, done, error);
    else pass_cnt++;
    send_byte(d[15:8], 1'b0);
    send_byte(d[7:0],  1'b0);
    send_word(32'h4, 32'h0123ABCD, 1'b0);
    wait_done(60, lat);
    chk_cnt++;
    if (lat !== 11 || we_cnt - w0 !== 2)
      $display("FAIL restart_ignore_load: got lat=%0d writes=%0d, required 11 2", lat, we_cnt - w0);
    else pass_cnt++;
  endtask

  task automatic test_full_capacity();
    int lat;
    int w0;
    logic [7:0] ib;
    w0 = we_cnt;
    do_start(9'd256);
    for (int i = 0; i < 256; i++) begin
      ib = i[7:0];
      send_word({22'h0, ib, 2'b00}, {ib, ~ib, 8'hA5, ib ^ 8'h3C}, 1'b0);
    end
    wait_done(100, lat);
    chk_cnt++;
    if (lat !== 1280 || we_cnt - w0 !== 256)
      $display("FAIL full_capacity: got lat=%0d writes=%0d, required 1280 256", lat, we_cnt - w0);
    else pass_cnt++;
    chk_cnt++;
    if (done !== 1'b1 || cpu_reset_n !== 1'b1)
      $display("FAIL full_capacity_done: got done=%b crn=%b, required 1 1", done, cpu_reset_n);
    else pass_cnt++;
  endtask

  initial begin
    rst_n            = 1'b0;
    start            = 1'b0;
    word_count       = '0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte_data  = '0;
    fork
      monitor_loop();
    join_none
    @(posedge clk);
    #1;
    test_reset();
    test_two_word();
    test_bubbled();
    test_bad_count();
    test_reset_mid();
    test_restart_ignore();
    test_full_capacity();
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
